// File: rtl/vq_pkg.sv
// rtl/vq_pkg.sv - shared VQ constants, state encoding and lane helper
package vq_pkg;

  localparam int LANES  = 8;
  localparam int IDX_W  = 3;
  localparam int RAM2_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } vq_state_e;

  // Lane 0 occupies the least significant index field of a RAM2 word.
  function automatic logic [IDX_W-1:0] lane_idx(input logic [RAM2_W-1:0] word, input int lane);
    return word[lane*IDX_W +: IDX_W];
  endfunction

endpackage

// File: rtl/vq_codebook_rf.sv
// rtl/vq_codebook_rf.sv - 8-entry codebook, one write port, eight combinational read ports
module vq_codebook_rf
  import vq_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       waddr,
  input  logic [PIX_W-1:0]       wdata,
  input  logic [RAM2_W-1:0]      ridx,
  output logic [LANES*PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_q [LANES];
  logic [PIX_W-1:0] mem_d [LANES];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_rd
    assign rdata[l*PIX_W +: PIX_W] = mem_q[lane_idx(ridx, l)];
  end

endmodule

// File: rtl/vq_index_decoder.sv
// rtl/vq_index_decoder.sv - streams RAM2 index words through the codebook into RAM3 pixel words
module vq_index_decoder
  import vq_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      num_words,
  input  logic                   cb_we,
  input  logic [IDX_W-1:0]       cb_addr,
  input  logic [PIX_W-1:0]       cb_data,
  output logic [ADDR_W-1:0]      RAM2_A,
  input  logic [RAM2_W-1:0]      RAM2_Q,
  output logic                   RAM3_WE,
  output logic [ADDR_W-1:0]      RAM3_A,
  output logic [LANES*PIX_W-1:0] RAM3_D,
  output logic [1:0]             state,
  output logic                   busy,
  output logic                   done
);

  vq_state_e              state_q, state_d;
  logic [ADDR_W-1:0]      ram2_a_q, ram2_a_d;
  logic [ADDR_W-1:0]      last_q, last_d;
  logic                   drain_q, drain_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic                   ram3_we_q, ram3_we_d;
  logic [ADDR_W-1:0]      ram3_a_q, ram3_a_d;
  logic [LANES*PIX_W-1:0] ram3_d_q, ram3_d_d;
  logic [LANES*PIX_W-1:0] cb_rdata;
  logic                   cb_wr_en;

  // Codebook only changes while idle so a decode always sees one consistent table.
  assign cb_wr_en = cb_we && (state_q == ST_IDLE);

  vq_codebook_rf #(
    .PIX_W (PIX_W)
  ) u_codebook (
    .clk   (clk),
    .rst_n (rst),
    .we    (cb_wr_en),
    .waddr (cb_addr),
    .wdata (cb_data),
    .ridx  (RAM2_Q),
    .rdata (cb_rdata)
  );

  always_comb begin
    state_d   = state_q;
    ram2_a_d  = ram2_a_q;
    last_d    = last_q;
    drain_d   = drain_q;
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    ram3_we_d = rd_vld_q;
    ram3_a_d  = ram3_a_q;
    ram3_d_d  = ram3_d_q;

    // RAM2_Q carries the word for rd_addr_q in the cycle rd_vld_q is high.
    if (rd_vld_q) begin
      ram3_a_d = rd_addr_q;
      ram3_d_d = cb_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            state_d  = ST_READ;
            ram2_a_d = '0;
            last_d   = num_words - ADDR_W'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        rd_vld_d  = 1'b1;
        rd_addr_d = ram2_a_q;
        if (ram2_a_q == last_q) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          ram2_a_d = ram2_a_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ram2_a_q  <= '0;
      last_q    <= '0;
      drain_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      ram3_we_q <= 1'b0;
      ram3_a_q  <= '0;
      ram3_d_q  <= '0;
    end else begin
      state_q   <= state_d;
      ram2_a_q  <= ram2_a_d;
      last_q    <= last_d;
      drain_q   <= drain_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      ram3_we_q <= ram3_we_d;
      ram3_a_q  <= ram3_a_d;
      ram3_d_q  <= ram3_d_d;
    end
  end

  assign RAM2_A  = ram2_a_q;
  assign RAM3_WE = ram3_we_q;
  assign RAM3_A  = ram3_a_q;
  assign RAM3_D  = ram3_d_q;
  assign state   = state_q;
  assign busy    = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_vq_index_decoder.sv
// tb/tb_vq_index_decoder.sv - directed self-checking bench for vq_index_decoder
module tb_vq_index_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [19:0] num_words = '0;
  logic        cb_we = 1'b0;
  logic [2:0]  cb_addr = '0;
  logic [7:0]  cb_data = '0;
  logic [19:0] RAM2_A;
  logic [23:0] RAM2_Q = '0;
  logic        RAM3_WE;
  logic [19:0] RAM3_A;
  logic [63:0] RAM3_D;
  logic [1:0]  state;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] ram2_mem [32];
  logic [7:0]  cb_model [8];
  logic [19:0] wr_a [$];
  logic [63:0] wr_d [$];
  int          wr_c [$];

  vq_index_decoder #(.ADDR_W(20), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .cb_we(cb_we), .cb_addr(cb_addr), .cb_data(cb_data),
    .RAM2_A(RAM2_A), .RAM2_Q(RAM2_Q), .RAM3_WE(RAM3_WE), .RAM3_A(RAM3_A),
    .RAM3_D(RAM3_D), .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    RAM2_Q <= ram2_mem[RAM2_A[4:0]];
    cyc    <= cyc + 1;
  end

  always @(negedge clk) begin
    if (RAM3_WE === 1'b1) begin
      wr_a.push_back(RAM3_A);
      wr_d.push_back(RAM3_D);
      wr_c.push_back(cyc);
    end
  end

  function automatic logic [63:0] exp_d(input logic [23:0] w);
    logic [63:0] r;
    logic [2:0]  ix;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      ix = w[l*3 +: 3];
      r[l*8 +: 8] = cb_model[ix];
    end
    return r;
  endfunction

  task automatic clear_mon();
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
  endtask

  task automatic load_cb();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cb_we = 1'b1;
      cb_addr = 3'(i);
      cb_data = 8'(i * 16 + 1);
      cb_model[i] = 8'(i * 16 + 1);
    end
    @(negedge clk);
    cb_we = 1'b0;
  endtask

  // Pulses start with n words; optionally pokes start and cb_we mid-READ.
  task automatic run_decode(input int n, input bit inject, output int done_at, output int done_cnt);
    @(posedge clk);
    #1;
    num_words = 20'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_at = -1;
    done_cnt = 0;
    for (int c = 1; c <= n + 12; c++) begin
      @(negedge clk);
      if (inject && c == 3) begin
        start = 1'b1;
        num_words = 20'd3;
        cb_we = 1'b1;
        cb_addr = 3'd3;
        cb_data = 8'hEE;
      end
      if (inject && c == 4) begin
        start = 1'b0;
        cb_we = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0h expected 0", state); end
    checks++; if (RAM2_A !== 20'h0) begin errors++; $display("FAIL reset_ram2_a: got %0h expected 0", RAM2_A); end
    checks++; if (RAM3_WE !== 1'b0) begin errors++; $display("FAIL reset_ram3_we: got %0b expected 0", RAM3_WE); end
    checks++; if (RAM3_A !== 20'h0) begin errors++; $display("FAIL reset_ram3_a: got %0h expected 0", RAM3_A); end
    checks++; if (RAM3_D !== 64'h0) begin errors++; $display("FAIL reset_ram3_d: got %0h expected 0", RAM3_D); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b%0b expected 00", busy, done); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    int da, dc;
    load_cb();
    ram2_mem[0] = 24'hFAC688;
    clear_mon();
    run_decode(1, 1'b0, da, dc);
    checks++; if (da !== 4) begin errors++; $display("FAIL single_done_latency: got %0d expected 4", da); end
    checks++; if (wr_a.size() !== 1) begin errors++; $display("FAIL single_wr_count: got %0d expected 1", wr_a.size()); end
    if (wr_a.size() >= 1) begin
      checks++; if (wr_a[0] !== 20'h0) begin errors++; $display("FAIL single_addr: got %0h expected 0", wr_a[0]); end
      checks++; if (wr_d[0] !== 64'h71615141_31211101) begin errors++; $display("FAIL single_data: got %0h expected 7161514131211101", wr_d[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int da, dc;
    for (int k = 0; k < 16; k++) ram2_mem[k] = 24'($urandom);
    clear_mon();
    run_decode(16, 1'b0, da, dc);
    checks++; if (da !== 19) begin errors++; $display("FAIL b2b_done_latency: got %0d expected 19", da); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", dc); end
    checks++; if (wr_a.size() !== 16) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 16", wr_a.size()); end
    for (int k = 0; k < 16 && k < wr_a.size(); k++) begin
      checks++; if (wr_a[k] !== 20'(k)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0h expected %0h", k, wr_a[k], k); end
      checks++; if (wr_d[k] !== exp_d(ram2_mem[k])) begin errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", k, wr_d[k], exp_d(ram2_mem[k])); end
      checks++; if (wr_c[k] !== wr_c[0] + k) begin errors++; $display("FAIL b2b_gap[%0d]: got cycle %0d expected %0d", k, wr_c[k], wr_c[0] + k); end
    end
  endtask

  task automatic test_zero();
    clear_mon();
    @(posedge clk);
    #1;
    num_words = 20'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'b11 || done !== 1'b1) begin errors++; $display("FAIL zero_done_state: got state %0h done %0b expected 3 1", state, done); end
    @(negedge clk);
    checks++; if (state !== 2'b00 || done !== 1'b0) begin errors++; $display("FAIL zero_idle_state: got state %0h done %0b expected 0 0", state, done); end
    repeat (5) @(negedge clk);
    checks++; if (wr_a.size() !== 0) begin errors++; $display("FAIL zero_no_write: got %0d writes expected 0", wr_a.size()); end
    checks++; if (RAM2_A !== 20'd15) begin errors++; $display("FAIL zero_ram2_a_hold: got %0h expected f", RAM2_A); end
  endtask

  task automatic test_ignore();
    int da, dc;
    for (int k = 0; k < 8; k++) ram2_mem[k] = (24'($urandom) & 24'hFFFFF8) | 24'h3;
    clear_mon();
    run_decode(8, 1'b1, da, dc);
    checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dc); end
    checks++; if (da !== 11) begin errors++; $display("FAIL ignore_done_latency: got %0d expected 11", da); end
    checks++; if (wr_a.size() !== 8) begin errors++; $display("FAIL ignore_wr_count: got %0d expected 8", wr_a.size()); end
    for (int k = 0; k < 8 && k < wr_a.size(); k++) begin
      checks++; if (wr_a[k] !== 20'(k) || wr_d[k] !== exp_d(ram2_mem[k])) begin errors++; $display("FAIL ignore_write[%0d]: got %0h/%0h expected %0h/%0h", k, wr_a[k], wr_d[k], k, exp_d(ram2_mem[k])); end
    end
  endtask

  task automatic test_reset_mid();
    int da, dc;
    bit hit;
    for (int k = 0; k < 8; k++) ram2_mem[k] = 24'($urandom);
    @(posedge clk);
    #1;
    num_words = 20'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (state === 2'b01 && RAM2_A === 20'd5) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_addr5: got %0b expected 1", hit); end
    rst = 1'b0;
    #1;
    checks++; if (state !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got %0h%0b%0b expected 000", state, busy, done); end
    checks++; if (RAM2_A !== 20'h0 || RAM3_A !== 20'h0) begin errors++; $display("FAIL rstmid_addr: got %0h/%0h expected 0/0", RAM2_A, RAM3_A); end
    checks++; if (RAM3_WE !== 1'b0 || RAM3_D !== 64'h0) begin errors++; $display("FAIL rstmid_ram3: got %0b/%0h expected 0/0", RAM3_WE, RAM3_D); end
    for (int i = 0; i < 8; i++) cb_model[i] = 8'h00;
    clear_mon();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (wr_a.size() !== 0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes expected 0", wr_a.size()); end
    ram2_mem[0] = 24'($urandom) | 24'h1;
    ram2_mem[1] = 24'($urandom) | 24'h2;
    clear_mon();
    run_decode(2, 1'b0, da, dc);
    checks++; if (da !== 5) begin errors++; $display("FAIL rstmid_redo_latency: got %0d expected 5", da); end
    checks++; if (wr_a.size() !== 2) begin errors++; $display("FAIL rstmid_redo_count: got %0d expected 2", wr_a.size()); end
    for (int k = 0; k < 2 && k < wr_a.size(); k++) begin
      checks++; if (wr_a[k] !== 20'(k) || wr_d[k] !== 64'h0) begin errors++; $display("FAIL rstmid_redo[%0d]: got %0h/%0h expected %0h/0", k, wr_a[k], wr_d[k], k); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram2_mem[i] = '0;
    for (int i = 0; i < 8; i++) cb_model[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
